// File: rtl/apb4_master_pkg.sv
// apb4_master_pkg
//   Shared types for the APB4 command master: the FSM state encoding, the
//   request record held for the duration of one APB transfer, and the
//   default protection attribute.
//   Configuration macro used by the master: APB4_CMD_MASTER_TIMEOUT_EN.
package apb4_master_pkg;

  // Default data path widths; the request record is sized from these, so the
  // master's ADDR_WIDTH/DATA_WIDTH parameters default to the same values.
  localparam int APB4_ADDR_WIDTH = 32;
  localparam int APB4_DATA_WIDTH = 32;
  localparam int APB4_STRB_WIDTH = APB4_DATA_WIDTH / 8;

  localparam logic [2:0] APB4_PROT_DEFAULT = 3'b000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb4_mst_state_e;

  typedef struct packed {
    logic [APB4_ADDR_WIDTH-1:0] addr;
    logic                       write;
    logic [APB4_DATA_WIDTH-1:0] wdata;
    logic [APB4_STRB_WIDTH-1:0] strb;
    logic [2:0]                 prot;
  } apb4_mst_req_t;

endpackage

// File: rtl/apb4_cmd_master.sv
// apb4_cmd_master
//   Bridges a valid/ready command stream onto an APB4 master port, one
//   transfer at a time: command accepted in IDLE, one SETUP cycle, ACCESS
//   until pready_i, then the response is held in RESP until consumed.
//   All APB request outputs are driven straight from registers.
//
//   Ports:
//     clk_i, rst_n_i              clock, asynchronous active-low reset
//     cmd_valid_i / cmd_ready_o   command handshake
//     cmd_write_i, cmd_addr_i,
//     cmd_wdata_i, cmd_strb_i,
//     cmd_prot_i                  command payload
//     rsp_valid_o / rsp_ready_i   response handshake
//     rsp_rdata_o, rsp_err_o      response payload (rdata is 0 for writes)
//     paddr_o .. pstrb_o          APB4 request
//     pready_i, prdata_i,
//     pslverr_i                   APB4 completion
//
//   Configuration macro APB4_CMD_MASTER_TIMEOUT_EN: when defined, an ACCESS
//   phase that sees TIMEOUT_CYC cycles of pready_i=0 is aborted and answered
//   with rsp_err_o=1 and rsp_rdata_o=0. When undefined, ACCESS waits forever.
module apb4_cmd_master
  import apb4_master_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB4_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB4_DATA_WIDTH,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
  input  logic [2:0]              cmd_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  apb4_mst_state_e state_q, state_d;
  apb4_mst_req_t   req_q, req_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

`ifdef APB4_CMD_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  // The timeout depth only matters when the abort counter is built.
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  // Next-state logic: every register holds by default, and each state only
  // touches what it owns. Reads zero pwdata/pstrb at latch time so the APB
  // request never carries stale write payload on a read.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
`ifdef APB4_CMD_MASTER_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          req_d.addr  = cmd_addr_i;
          req_d.write = cmd_write_i;
          req_d.wdata = cmd_write_i ? cmd_wdata_i : '0;
          req_d.strb  = cmd_write_i ? cmd_strb_i : '0;
          req_d.prot  = cmd_prot_i;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB4_CMD_MASTER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        // pready_i is checked first so a completion on the expiry cycle wins.
        if (pready_i) begin
          rdata_d   = req_q.write ? '0 : prdata_i;
          err_d     = pslverr_i;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = RESP;
        end
`ifdef APB4_CMD_MASTER_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT_CYC)) begin
            rdata_d   = '0;
            err_d     = 1'b1;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = RESP;
          end
        end
`endif
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset drops any transfer in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      req_q     <= '{addr: '0, write: 1'b0, wdata: '0, strb: '0,
                     prot: APB4_PROT_DEFAULT};
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef APB4_CMD_MASTER_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
`ifdef APB4_CMD_MASTER_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign paddr_o     = req_q.addr;
  assign pprot_o     = req_q.prot;
  assign pwrite_o    = req_q.write;
  assign pwdata_o    = req_q.wdata;
  assign pstrb_o     = req_q.strb;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;

endmodule

// File: tb/tb_apb4_cmd_master.sv
// tb_apb4_cmd_master
//   Directed bench for apb4_cmd_master: write, read, wait states, error with
//   response backpressure, reset mid-ACCESS and (with
//   APB4_CMD_MASTER_TIMEOUT_EN) the ACCESS timeout with TIMEOUT_CYC=8.
module tb_apb4_cmd_master;

  logic        clk;
  logic        rstN;
  logic        cmdValid;
  logic        cmdReady;
  logic        cmdWrite;
  logic [31:0] cmdAddr;
  logic [31:0] cmdWdata;
  logic [3:0]  cmdStrb;
  logic [2:0]  cmdProt;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspRdata;
  logic        rspErr;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int compared = 0;
  int mismatched = 0;

  apb4_cmd_master #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rstN),
    .cmd_valid_i(cmdValid),
    .cmd_ready_o(cmdReady),
    .cmd_write_i(cmdWrite),
    .cmd_addr_i (cmdAddr),
    .cmd_wdata_i(cmdWdata),
    .cmd_strb_i (cmdStrb),
    .cmd_prot_i (cmdProt),
    .rsp_valid_o(rspValid),
    .rsp_ready_i(rspReady),
    .rsp_rdata_o(rspRdata),
    .rsp_err_o  (rspErr),
    .paddr_o    (paddr),
    .pprot_o    (pprot),
    .psel_o     (psel),
    .penable_o  (penable),
    .pwrite_o   (pwrite),
    .pwdata_o   (pwdata),
    .pstrb_o    (pstrb),
    .pready_i   (pready),
    .prdata_i   (prdata),
    .pslverr_i  (pslverr)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it, so inputs change and
  // outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command on the command port.
  task automatic applyStimulus(input logic valid, input logic write,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input logic [2:0] prot);
    cmdValid = valid;
    cmdWrite = write;
    cmdAddr  = addr;
    cmdWdata = wdata;
    cmdStrb  = strb;
    cmdProt  = prot;
  endtask

  // One comparison against a hand-computed expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rstN     = 1'b0;
    rspReady = 1'b0;
    pready   = 1'b0;
    prdata   = 32'h0;
    pslverr  = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    tick();
    tick();

    // Reset values
    checkOutput("rst_cmd_ready", 32'(cmdReady), 32'd1);
    checkOutput("rst_psel", 32'(psel), 32'd0);
    checkOutput("rst_penable", 32'(penable), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("rst_paddr", paddr, 32'h0);
    checkOutput("rst_rsp_err", 32'(rspErr), 32'd0);
    rstN = 1'b1;
    tick();

    // Write 0x04 <= 0xDEADBEEF, pready high, prdata nonzero to prove rdata=0
    $display("[TB] write with zero wait states");
    pready = 1'b1;
    prdata = 32'h0000_CAFE;
    applyStimulus(1'b1, 1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF, 3'b010);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    checkOutput("wr_setup_psel", 32'(psel), 32'd1);
    checkOutput("wr_setup_penable", 32'(penable), 32'd0);
    checkOutput("wr_setup_pwdata", pwdata, 32'hDEAD_BEEF);
    checkOutput("wr_setup_paddr", paddr, 32'h04);
    checkOutput("wr_setup_pwrite", 32'(pwrite), 32'd1);
    checkOutput("wr_setup_pstrb", 32'(pstrb), 32'hF);
    checkOutput("wr_setup_pprot", 32'(pprot), 32'd2);
    checkOutput("wr_setup_cmd_ready", 32'(cmdReady), 32'd0);
    tick();
    checkOutput("wr_access_psel", 32'(psel), 32'd1);
    checkOutput("wr_access_penable", 32'(penable), 32'd1);
    checkOutput("wr_access_pwdata", pwdata, 32'hDEAD_BEEF);
    checkOutput("wr_access_rsp_valid", 32'(rspValid), 32'd0);
    tick();
    checkOutput("wr_resp_valid", 32'(rspValid), 32'd1);
    checkOutput("wr_resp_psel", 32'(psel), 32'd0);
    checkOutput("wr_resp_penable", 32'(penable), 32'd0);
    checkOutput("wr_resp_err", 32'(rspErr), 32'd0);
    checkOutput("wr_resp_rdata", rspRdata, 32'h0);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    checkOutput("wr_done_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("wr_done_cmd_ready", 32'(cmdReady), 32'd1);

    // Read 0x08; payload fields on the command must not reach the bus
    $display("[TB] read with zero wait states");
    prdata = 32'h0000_1234;
    applyStimulus(1'b1, 1'b0, 32'h08, 32'h5555_5555, 4'hF, 3'b000);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    checkOutput("rd_setup_paddr", paddr, 32'h08);
    checkOutput("rd_setup_pwrite", 32'(pwrite), 32'd0);
    checkOutput("rd_setup_pstrb", 32'(pstrb), 32'd0);
    checkOutput("rd_setup_pwdata", pwdata, 32'h0);
    tick();
    checkOutput("rd_access_penable", 32'(penable), 32'd1);
    checkOutput("rd_access_pstrb", 32'(pstrb), 32'd0);
    tick();
    checkOutput("rd_resp_valid", 32'(rspValid), 32'd1);
    checkOutput("rd_resp_rdata", rspRdata, 32'h0000_1234);
    checkOutput("rd_resp_err", 32'(rspErr), 32'd0);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    checkOutput("rd_done_cmd_ready", 32'(cmdReady), 32'd1);

    // Three wait states: ACCESS lasts 4 cycles, response 5 cycles after accept
    $display("[TB] write with three wait states");
    pready = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h10, 32'h0BAD_F00D, 4'h3, 3'b000);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    checkOutput("ws_setup_penable", 32'(penable), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("ws_access%0d_penable", i), 32'(penable), 32'd1);
      checkOutput($sformatf("ws_access%0d_paddr", i), paddr, 32'h10);
      checkOutput($sformatf("ws_access%0d_pwdata", i), pwdata, 32'h0BAD_F00D);
      checkOutput($sformatf("ws_access%0d_rsp_valid", i), 32'(rspValid), 32'd0);
      if (i == 3) pready = 1'b1;
    end
    tick();
    checkOutput("ws_resp_valid", 32'(rspValid), 32'd1);
    checkOutput("ws_resp_psel", 32'(psel), 32'd0);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;

    // Slave error with response backpressure and a second command waiting
    $display("[TB] slave error under response backpressure");
    pslverr = 1'b1;
    prdata  = 32'h0000_0077;
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h30, 32'h1111_2222, 4'hF, 3'b000);
    checkOutput("err_setup_cmd_ready", 32'(cmdReady), 32'd0);
    tick();
    checkOutput("err_access_cmd_ready", 32'(cmdReady), 32'd0);
    tick();
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("err_hold%0d_rsp_valid", i), 32'(rspValid), 32'd1);
      checkOutput($sformatf("err_hold%0d_rsp_err", i), 32'(rspErr), 32'd1);
      checkOutput($sformatf("err_hold%0d_rsp_rdata", i), rspRdata, 32'h0000_0077);
      checkOutput($sformatf("err_hold%0d_cmd_ready", i), 32'(cmdReady), 32'd0);
      checkOutput($sformatf("err_hold%0d_psel", i), 32'(psel), 32'd0);
      if (i < 5) tick();
    end
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    pslverr  = 1'b0;
    checkOutput("err_done_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("err_done_cmd_ready", 32'(cmdReady), 32'd1);
    checkOutput("err_done_psel", 32'(psel), 32'd0);
    pready = 1'b0;
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    checkOutput("second_setup_psel", 32'(psel), 32'd1);
    checkOutput("second_setup_paddr", paddr, 32'h30);
    checkOutput("second_setup_pwdata", pwdata, 32'h1111_2222);
    tick();
    checkOutput("second_access_penable", 32'(penable), 32'd1);

    // Reset while stalled in ACCESS
    $display("[TB] reset mid-ACCESS");
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midrst_psel", 32'(psel), 32'd0);
    checkOutput("midrst_penable", 32'(penable), 32'd0);
    checkOutput("midrst_rsp_valid", 32'(rspValid), 32'd0);
    tick();
    pready  = 1'b1;
    pslverr = 1'b1;
    rstN    = 1'b1;
    tick();
    checkOutput("postrst_cmd_ready", 32'(cmdReady), 32'd1);
    checkOutput("postrst_rsp_valid", 32'(rspValid), 32'd0);
    tick();
    checkOutput("idle_pready_ignored_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("idle_pready_ignored_cmd_ready", 32'(cmdReady), 32'd1);
    pslverr = 1'b0;

`ifdef APB4_CMD_MASTER_TIMEOUT_EN
    // pready held low: abort after 8 ACCESS wait cycles
    $display("[TB] ACCESS timeout");
    pready = 1'b0;
    prdata = 32'hFFFF_FFFF;
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkOutput($sformatf("to_wait%0d_psel", i), 32'(psel), 32'd1);
      checkOutput($sformatf("to_wait%0d_rsp_valid", i), 32'(rspValid), 32'd0);
    end
    tick();
    checkOutput("to_abort_psel", 32'(psel), 32'd0);
    checkOutput("to_abort_penable", 32'(penable), 32'd0);
    checkOutput("to_abort_rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("to_abort_rsp_err", 32'(rspErr), 32'd1);
    checkOutput("to_abort_rsp_rdata", rspRdata, 32'h0);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    checkOutput("to_done_cmd_ready", 32'(cmdReady), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
